// File: rtl/data_mem_io_if.sv
// Processor data-port bus: byte address, store byte with lane enables,
// store strobe, and the combinational 32-bit read word returned by memory.
interface data_mem_io_if;
  logic [7:0]  access_address;
  logic [7:0]  data_write;
  logic [3:0]  byte_enable;
  logic        write_enable;
  logic [31:0] data_read;

  modport master (
    output access_address,
    output data_write,
    output byte_enable,
    output write_enable,
    input  data_read
  );

  modport slave (
    input  access_address,
    input  data_write,
    input  byte_enable,
    input  write_enable,
    output data_read
  );
endinterface

// File: rtl/data_mem_io.sv
// Data-side memory subsystem: 64 x 32-bit byte-lane RAM with zero-latency
// reads, plus an I/O window at words 56..59 holding a GPIO register,
// a prescaled compare timer with level IRQ, and an 8N1 UART transmitter.
module data_mem_io #(
  parameter int RAM_WORDS = 64,
  parameter int TIMER_DIV = 16,
  parameter int BAUD_DIV  = 434
) (
  input  logic         clk,
  input  logic         reset,
  data_mem_io_if.slave bus,
  output logic [7:0]   gpio_out,
  output logic         timer_irq,
  output logic         uart_tx
);

  localparam int PW = (TIMER_DIV > 1) ? $clog2(TIMER_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(TIMER_DIV - 1);
  localparam int BW = $clog2(BAUD_DIV);
  localparam logic [BW-1:0] BAUD_LAST = BW'(BAUD_DIV - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } uart_state_t;

  // ---------------------------------------------------------------- decode
  logic [5:0] word_idx;
  logic       is_io;
  logic       is_gpio;
  logic       is_timer;
  logic       is_uart;
  logic [3:0] lane_we;
  logic       ram_we;
  logic       unused_addr_bits;

  assign word_idx         = bus.access_address[7:2];
  assign unused_addr_bits = ^bus.access_address[1:0];
  // Words 56..59 form the I/O window; RAM words at those indices stay untouched.
  assign is_io    = (word_idx[5:2] == 4'b1110);
  assign is_gpio  = (word_idx == 6'd56);
  assign is_timer = (word_idx == 6'd57);
  assign is_uart  = (word_idx == 6'd58);
  assign lane_we  = {4{bus.write_enable}} & bus.byte_enable;
  assign ram_we   = bus.write_enable & ~is_io;

  // ---------------------------------------------------------------- RAM
  logic [31:0] ram_rdata;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      logic [7:0] mem [RAM_WORDS];

      // Byte-lane store; contents survive reset.
      always_ff @(posedge clk) begin
        if (ram_we && bus.byte_enable[gi]) begin
          mem[word_idx] <= bus.data_write;
        end
      end

      assign ram_rdata[gi*8 +: 8] = mem[word_idx];
    end
  endgenerate

  // ---------------------------------------------------------------- GPIO
  logic [7:0] gpio_reg;

  // GPIO output register, lane 0 only.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      gpio_reg <= 8'h00;
    end else if (is_gpio && lane_we[0]) begin
      gpio_reg <= bus.data_write;
    end
  end

  assign gpio_out = gpio_reg;

  // ---------------------------------------------------------------- timer
  logic [7:0]    count_reg;
  logic [7:0]    compare_reg;
  logic          ctrl_en_reg;
  logic          ctrl_ar_reg;
  logic          ctrl_ie_reg;
  logic          match_reg;
  logic [PW-1:0] presc_reg;

  logic       wr_count;
  logic       wr_compare;
  logic       wr_ctrl;
  logic       clr_match;
  logic       tick;
  logic [7:0] count_inc;
  logic       tick_match;

  assign wr_count   = is_timer & lane_we[0];
  assign wr_compare = is_timer & lane_we[1];
  assign wr_ctrl    = is_timer & lane_we[2];
  assign clr_match  = is_timer & lane_we[3] & bus.data_write[0];
  // A software count write discards any tick landing in the same cycle.
  assign tick       = ctrl_en_reg & (presc_reg == PRESC_LAST) & ~wr_count;
  assign count_inc  = count_reg + 8'd1;
  assign tick_match = tick & (count_inc == compare_reg);

  // Prescaler, counter, compare/ctrl registers and sticky match flag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_reg   <= 8'h00;
      compare_reg <= 8'h00;
      ctrl_en_reg <= 1'b0;
      ctrl_ar_reg <= 1'b0;
      ctrl_ie_reg <= 1'b0;
      match_reg   <= 1'b0;
      presc_reg   <= '0;
    end else begin
      if (wr_compare) begin
        compare_reg <= bus.data_write;
      end
      if (wr_ctrl) begin
        ctrl_en_reg <= bus.data_write[0];
        ctrl_ar_reg <= bus.data_write[1];
        ctrl_ie_reg <= bus.data_write[2];
      end
      if (wr_count) begin
        count_reg <= bus.data_write;
        presc_reg <= '0;
      end else if (tick) begin
        presc_reg <= '0;
        count_reg <= (tick_match && ctrl_ar_reg) ? 8'h00 : count_inc;
      end else if (ctrl_en_reg) begin
        presc_reg <= presc_reg + 1'b1;
      end
      // Set beats clear when both happen together.
      if (tick_match) begin
        match_reg <= 1'b1;
      end else if (clr_match) begin
        match_reg <= 1'b0;
      end
    end
  end

  assign timer_irq = match_reg & ctrl_ie_reg;

  // ---------------------------------------------------------------- UART
  uart_state_t   state_reg, state_next;
  logic [BW-1:0] baud_cnt_reg, baud_cnt_next;
  logic [2:0]    bit_idx_reg, bit_idx_next;
  logic [7:0]    shift_reg, shift_next;
  logic          tx_reg, tx_next;
  logic          baud_end;
  logic          uart_busy;
  logic          launch;

  assign baud_end  = (baud_cnt_reg == BAUD_LAST);
  assign uart_busy = (state_reg != S_IDLE);
  assign launch    = is_uart & lane_we[0];

  // UART state register; reset aborts any frame and idles the line high.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg    <= S_IDLE;
      baud_cnt_reg <= '0;
      bit_idx_reg  <= 3'd0;
      shift_reg    <= 8'h00;
      tx_reg       <= 1'b1;
    end else begin
      state_reg    <= state_next;
      baud_cnt_reg <= baud_cnt_next;
      bit_idx_reg  <= bit_idx_next;
      shift_reg    <= shift_next;
      tx_reg       <= tx_next;
    end
  end

  // Frame sequencing: start bit, 8 data bits LSB first, stop bit.
  always_comb begin
    state_next    = state_reg;
    baud_cnt_next = baud_cnt_reg;
    bit_idx_next  = bit_idx_reg;
    shift_next    = shift_reg;
    case (state_reg)
      S_IDLE: begin
        if (launch) begin
          state_next    = S_START;
          shift_next    = bus.data_write;
          baud_cnt_next = '0;
        end
      end
      S_START: begin
        if (baud_end) begin
          state_next    = S_DATA;
          baud_cnt_next = '0;
          bit_idx_next  = 3'd0;
        end else begin
          baud_cnt_next = baud_cnt_reg + 1'b1;
        end
      end
      S_DATA: begin
        if (baud_end) begin
          baud_cnt_next = '0;
          if (bit_idx_reg == 3'd7) begin
            state_next = S_STOP;
          end else begin
            bit_idx_next = bit_idx_reg + 3'd1;
            shift_next   = {1'b0, shift_reg[7:1]};
          end
        end else begin
          baud_cnt_next = baud_cnt_reg + 1'b1;
        end
      end
      S_STOP: begin
        if (baud_end) begin
          state_next    = S_IDLE;
          baud_cnt_next = '0;
        end else begin
          baud_cnt_next = baud_cnt_reg + 1'b1;
        end
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
    // Line level follows the state being entered so the output is registered.
    case (state_next)
      S_START: tx_next = 1'b0;
      S_DATA:  tx_next = shift_next[0];
      default: tx_next = 1'b1;
    endcase
  end

  assign uart_tx = tx_reg;

  // ---------------------------------------------------------------- read mux
  logic [31:0] rd_data;

  // Zero-latency read of the addressed word, RAM or I/O register.
  always_comb begin
    rd_data = ram_rdata;
    if (is_io) begin
      rd_data = 32'h0;
      case (word_idx[1:0])
        2'd0: rd_data = {24'h0, gpio_reg};
        2'd1: rd_data = {7'h0, match_reg, 5'h0, ctrl_ie_reg, ctrl_ar_reg, ctrl_en_reg,
                         compare_reg, count_reg};
        2'd2: rd_data = {23'h0, uart_busy, 8'h0};
        default: rd_data = 32'h0;
      endcase
    end
  end

  assign bus.data_read = rd_data;

endmodule

// File: tb/tb_data_mem_io.sv
// Directed bench for data_mem_io: RAM lanes and same-cycle readback, GPIO,
// timer compare/IRQ/count-write priority, UART framing, async reset.
module tb_data_mem_io;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] gpio_out;
  logic       timer_irq;
  logic       uart_tx;

  int checks = 0;
  int failures = 0;

  typedef struct {
    string       tag;
    logic [31:0] exp;
  } exp_t;

  exp_t sb[$];

  data_mem_io_if bus();

  data_mem_io #(
    .RAM_WORDS(64),
    .TIMER_DIV(4),
    .BAUD_DIV (4)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .bus      (bus),
    .gpio_out (gpio_out),
    .timer_irq(timer_irq),
    .uart_tx  (uart_tx)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic push(input string tag, input logic [31:0] exp);
    exp_t e;
    e.tag = tag;
    e.exp = exp;
    sb.push_back(e);
  endtask

  task automatic pop_check(input logic [31:0] obs);
    exp_t e;
    if (sb.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL scoreboard_empty observed=0x%08h expected=none", obs);
    end else begin
      e = sb.pop_front();
      check(e.tag, obs, e.exp);
    end
  endtask

  task automatic wr(input logic [7:0] a, input logic [7:0] d, input logic [3:0] be);
    bus.access_address = a;
    bus.data_write     = d;
    bus.byte_enable    = be;
    bus.write_enable   = 1'b1;
    @(posedge clk);
    #1;
    bus.write_enable = 1'b0;
    bus.byte_enable  = 4'b0000;
  endtask

  task automatic rd_check(input logic [7:0] a, input string tag, input logic [31:0] exp);
    bus.access_address = a;
    #1;
    check(tag, bus.data_read, exp);
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [9:0] frame;

    bus.access_address = 8'h00;
    bus.data_write     = 8'h00;
    bus.byte_enable    = 4'b0000;
    bus.write_enable   = 1'b0;
    reset              = 1'b0;

    // Reset state
    cyc(3);
    check("rst_gpio", {24'h0, gpio_out}, 32'h0);
    check("rst_irq", {31'h0, timer_irq}, 32'h0);
    check("rst_tx", {31'h0, uart_tx}, 32'h1);
    rd_check(8'hE0, "rst_rd_gpio", 32'h0);
    rd_check(8'hE4, "rst_rd_timer", 32'h0);
    rd_check(8'hE8, "rst_rd_uart", 32'h0);
    @(negedge clk);
    reset = 1'b1;
    cyc(1);

    // RAM byte lanes and same-cycle readback
    wr(8'h10, 8'hA5, 4'b0001);
    bus.access_address = 8'h11;
    bus.data_write     = 8'h3C;
    bus.byte_enable    = 4'b0010;
    bus.write_enable   = 1'b1;
    #1;
    check("ram_same_cycle_old", bus.data_read, 32'h0000_00A5);
    @(posedge clk);
    #1;
    bus.write_enable = 1'b0;
    bus.byte_enable  = 4'b0000;
    rd_check(8'h10, "ram_new", 32'h0000_3CA5);
    rd_check(8'h13, "ram_addr_lsb_ignored", 32'h0000_3CA5);
    wr(8'h10, 8'h00, 4'b0000);
    rd_check(8'h10, "ram_be_zero", 32'h0000_3CA5);
    wr(8'hFC, 8'h77, 4'b1111);
    rd_check(8'hFC, "ram_last_word", 32'h7777_7777);
    wr(8'hDC, 8'h11, 4'b1000);
    rd_check(8'hDC, "ram_word55", 32'h1100_0000);
    wr(8'hEC, 8'hFF, 4'b1111);
    rd_check(8'hEC, "io_w59_zero", 32'h0);
    rd_check(8'hF0, "ram_word60_init", 32'h0);

    // GPIO
    wr(8'hE0, 8'h5A, 4'b0001);
    check("gpio_out", {24'h0, gpio_out}, 32'h5A);
    rd_check(8'hE0, "gpio_rd", 32'h0000_005A);
    wr(8'hE0, 8'hFF, 4'b1110);
    rd_check(8'hE0, "gpio_upper_lanes", 32'h0000_005A);
    rd_check(8'h10, "ram_after_gpio", 32'h0000_3CA5);

    // Timer: compare=3, enable+auto_reload+irq_en (edge E0)
    wr(8'hE4, 8'h03, 4'b0010);
    wr(8'hE4, 8'h07, 4'b0100);
    cyc(11);
    check("tmr_irq_before", {31'h0, timer_irq}, 32'h0);
    rd_check(8'hE4, "tmr_count2", 32'h0007_0302);
    cyc(1);
    check("tmr_irq_match", {31'h0, timer_irq}, 32'h1);
    rd_check(8'hE4, "tmr_reload", 32'h0107_0300);
    wr(8'hE4, 8'h01, 4'b1000);
    check("tmr_irq_cleared", {31'h0, timer_irq}, 32'h0);
    rd_check(8'hE4, "tmr_flag_cleared", 32'h0007_0300);
    cyc(10);
    check("tmr_irq_before2", {31'h0, timer_irq}, 32'h0);
    rd_check(8'hE4, "tmr_count2b", 32'h0007_0302);
    cyc(1);
    check("tmr_irq_match2", {31'h0, timer_irq}, 32'h1);
    rd_check(8'hE4, "tmr_reload2", 32'h0107_0300);

    // Count write coinciding with a tick, then mid-prescaler count write
    cyc(3);
    wr(8'hE4, 8'h80, 4'b0001);
    rd_check(8'hE4, "tmr_wr_wins", 32'h0107_0380);
    cyc(3);
    rd_check(8'hE4, "tmr_hold_80", 32'h0107_0380);
    cyc(1);
    rd_check(8'hE4, "tmr_tick_81", 32'h0107_0381);
    cyc(1);
    wr(8'hE4, 8'h10, 4'b0001);
    cyc(3);
    rd_check(8'hE4, "tmr_presc_restart", 32'h0107_0310);
    cyc(1);
    rd_check(8'hE4, "tmr_tick_11", 32'h0107_0311);

    // Disable: count frozen, irq masked with flag still set
    wr(8'hE4, 8'h00, 4'b0100);
    check("tmr_irq_masked", {31'h0, timer_irq}, 32'h0);
    cyc(8);
    rd_check(8'hE4, "tmr_frozen", 32'h0100_0311);

    // UART 0x81 frame, with an ignored write during bit 3
    frame = {1'b1, 8'h81, 1'b0};
    wr(8'hE8, 8'h81, 4'b0001);
    for (int i = 0; i < 10; i++) begin
      push($sformatf("uart_bit%0d", i), {31'h0, frame[i]});
    end
    rd_check(8'hE8, "uart_busy_start", 32'h0000_0100);
    for (int b = 0; b < 10; b++) begin
      cyc(2);
      pop_check({31'h0, uart_tx});
      if (b == 3) begin
        wr(8'hE8, 8'hFF, 4'b0001);
        cyc(1);
      end else if (b == 9) begin
        cyc(1);
        rd_check(8'hE8, "uart_busy_last", 32'h0000_0100);
        cyc(1);
        rd_check(8'hE8, "uart_idle_after", 32'h0);
        check("uart_tx_idle", {31'h0, uart_tx}, 32'h1);
      end else begin
        cyc(2);
      end
    end
    check("sb_drained", sb.size(), 32'h0);

    // Async reset mid-frame with timer running and irq asserted
    wr(8'hE4, 8'h05, 4'b0100);
    check("tmr_irq_reenabled", {31'h0, timer_irq}, 32'h1);
    wr(8'hE8, 8'h00, 4'b0001);
    cyc(6);
    push("uart_mid_frame", 32'h0);
    pop_check({31'h0, uart_tx});
    rd_check(8'hE8, "uart_busy_mid", 32'h0000_0100);
    #2;
    reset = 1'b0;
    #1;
    check("arst_gpio", {24'h0, gpio_out}, 32'h0);
    check("arst_irq", {31'h0, timer_irq}, 32'h0);
    check("arst_tx", {31'h0, uart_tx}, 32'h1);
    rd_check(8'hE8, "arst_uart", 32'h0);
    rd_check(8'hE4, "arst_timer", 32'h0);
    rd_check(8'hE0, "arst_rd_gpio", 32'h0);
    @(negedge clk);
    reset = 1'b1;
    cyc(2);
    rd_check(8'h10, "ram_retained", 32'h0000_3CA5);
    rd_check(8'hFC, "ram_retained_last", 32'h7777_7777);
    rd_check(8'hE4, "post_rst_timer", 32'h0);
    check("post_rst_tx", {31'h0, uart_tx}, 32'h1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
